// File: rtl/noc_output_vc_scheduler_pkg.sv
// Shared NoC parameters and types for the output VC scheduler and its credit counters.
package Noc_parameters;
  localparam int Noc_VC_Channel   = 4;
  localparam int Noc_Credit_Depth = 4;

  typedef logic [$clog2(Noc_VC_Channel)-1:0] noc_vc_idx_t;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_IN   = 1'b1
  } pkt_state_e;

  // VC index width, never narrower than one bit so single-VC builds keep a real link_vc port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_output_vc_scheduler_credit_counter.sv
// Per-VC downstream credit counter: saturating up/down with simultaneous inc/dec.
module noc_credit_counter
  import Noc_parameters::*;
#(
  parameter int DEPTH = Noc_Credit_Depth,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic noc_clk,
  input  logic noc_rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic ovf_o
);
  logic [CW-1:0] count_q, count_d;

  // Send and return together cancel; a lone return to a full counter is an overflow.
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CW'(DEPTH)) ovf_o = 1'b1;
      else                       count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) count_q <= CW'(DEPTH);
    else         count_q <= count_d;
  end

  assign nonzero_o = (count_q != '0);
endmodule

// File: rtl/noc_output_vc_scheduler.sv
// Credit-based round-robin link scheduler for one router output port.
module noc_output_vc_scheduler
  import Noc_parameters::*;
#(
  parameter int CHANNELS     = Noc_VC_Channel,
  parameter int CREDIT_DEPTH = Noc_Credit_Depth,
  localparam int IW          = idx_width(CHANNELS),
  localparam int IW1         = IW + 1
) (
  input  logic                noc_clk,
  input  logic                noc_rst,
  input  logic [CHANNELS-1:0] vc_valid,
  input  logic [CHANNELS-1:0] vc_sop,
  input  logic [CHANNELS-1:0] vc_eop,
  output logic [CHANNELS-1:0] vc_pop,
  output logic                link_valid,
  output logic [IW-1:0]       link_vc,
  output logic                link_sop,
  output logic                link_eop,
  input  logic                credit_valid,
  input  logic [IW-1:0]       credit_vc,
  output logic [CHANNELS-1:0] vc_ready,
  output logic                err_credit_ovf,
  output logic                err_protocol
);
  logic [CHANNELS-1:0] credit_nz, credit_ovf, credit_inc, elig, gnt, proto_viol;
  logic [IW-1:0]       ptr_q, ptr_d, gidx, link_vc_q;
  logic [IW1-1:0]      idx;
  logic                gnt_any;
  logic                link_valid_q, link_sop_q, link_eop_q, err_ovf_q, err_proto_q;
  pkt_state_e          state_q [CHANNELS];
  pkt_state_e          state_d [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
      assign credit_inc[gi] = credit_valid && (credit_vc == IW'(gi));
      noc_credit_counter #(.DEPTH(CREDIT_DEPTH)) u_cnt (
        .noc_clk   (noc_clk),
        .noc_rst   (noc_rst),
        .inc_i     (credit_inc[gi]),
        .dec_i     (gnt[gi]),
        .nonzero_o (credit_nz[gi]),
        .ovf_o     (credit_ovf[gi])
      );
    end
  endgenerate

  // Eligibility looks only at registered credit; a credit returned this cycle helps next cycle.
  assign elig = vc_valid & credit_nz;

  // Scan from the far end so the lowest offset from the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = '0;
    gnt     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + IW1'(k);
      if (idx >= IW1'(CHANNELS)) idx = idx - IW1'(CHANNELS);
      if (elig[idx[IW-1:0]]) begin
        gnt_any = 1'b1;
        gidx    = idx[IW-1:0];
      end
    end
    if (noc_rst) gnt_any = 1'b0;
    if (gnt_any) gnt[gidx] = 1'b1;
  end

  assign vc_pop = gnt;
  assign ptr_d  = !gnt_any ? ptr_q : (gidx == IW'(CHANNELS - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge noc_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (noc_rst) state_q[c] <= PKT_IDLE;
      else         state_q[c] <= state_d[c];
    end
  end

  // Even a malformed flit is forwarded, so the next state always follows its tail flag.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      if (gnt[c]) state_d[c] = vc_eop[c] ? PKT_IDLE : PKT_IN;
    end
  end

  always_comb begin
    proto_viol = '0;
    for (int c = 0; c < CHANNELS; c++)
      proto_viol[c] = gnt[c] && ((state_q[c] == PKT_IDLE) ? !vc_sop[c] : vc_sop[c]);
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      ptr_q        <= '0;
      link_valid_q <= 1'b0;
      link_vc_q    <= '0;
      link_sop_q   <= 1'b0;
      link_eop_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      link_valid_q <= gnt_any;
      link_vc_q    <= gidx;
      link_sop_q   <= gnt_any && vc_sop[gidx];
      link_eop_q   <= gnt_any && vc_eop[gidx];
      err_ovf_q    <= err_ovf_q | (|credit_ovf);
      err_proto_q  <= err_proto_q | (|proto_viol);
    end
  end

  assign link_valid     = link_valid_q;
  assign link_vc        = link_vc_q;
  assign link_sop       = link_sop_q;
  assign link_eop       = link_eop_q;
  assign vc_ready       = credit_nz;
  assign err_credit_ovf = err_ovf_q;
  assign err_protocol   = err_proto_q;
endmodule

// File: tb/tb_noc_output_vc_scheduler.sv
// Directed bench: expected link flits queued at grant time, checked by a negedge monitor.
module tb_noc_output_vc_scheduler;
  logic       noc_clk = 1'b0;
  logic       noc_rst;
  logic [1:0] vc_valid, vc_sop, vc_eop, vc_pop, vc_ready;
  logic       link_valid, link_sop, link_eop, credit_valid;
  logic       err_credit_ovf, err_protocol;
  logic [0:0] link_vc, credit_vc;

  typedef struct packed {
    logic vc;
    logic sop;
    logic eop;
  } flit_t;

  flit_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 noc_clk = ~noc_clk;

  noc_output_vc_scheduler #(.CHANNELS(2), .CREDIT_DEPTH(4)) dut (
    .noc_clk        (noc_clk),
    .noc_rst        (noc_rst),
    .vc_valid       (vc_valid),
    .vc_sop         (vc_sop),
    .vc_eop         (vc_eop),
    .vc_pop         (vc_pop),
    .link_valid     (link_valid),
    .link_vc        (link_vc),
    .link_sop       (link_sop),
    .link_eop       (link_eop),
    .credit_valid   (credit_valid),
    .credit_vc      (credit_vc),
    .vc_ready       (vc_ready),
    .err_credit_ovf (err_credit_ovf),
    .err_protocol   (err_protocol)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check the combinational pop, queue the flit that must follow.
  task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                     input logic cv, input logic cvc, input logic [1:0] ep);
    flit_t f;
    noc_rst = r; vc_valid = v; vc_sop = s; vc_eop = e;
    credit_valid = cv; credit_vc = cvc;
    #1;
    chk("vc_pop", {30'd0, vc_pop}, {30'd0, ep});
    @(posedge noc_clk);
    if (ep != 2'b00) begin
      f.vc  = ep[1];
      f.sop = s[ep[1]];
      f.eop = e[ep[1]];
      exp_q.push_back(f);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
  endtask

  always @(negedge noc_clk) begin
    flit_t f;
    if (link_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL link_unexpected: got vc %0d with nothing expected at %0t", link_vc, $time);
      end else begin
        f = exp_q.pop_front();
        chk("link_vc",  {31'd0, link_vc},  {31'd0, f.vc});
        chk("link_sop", {31'd0, link_sop}, {31'd0, f.sop});
        chk("link_eop", {31'd0, link_eop}, {31'd0, f.eop});
      end
    end else if (exp_q.size() != 0) begin
      tests++; fails++;
      f = exp_q.pop_front();
      $display("FAIL link_missing: got link_valid 0 expected vc %0d at %0t", f.vc, $time);
    end
  end

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("rst_link_valid", {31'd0, link_valid}, 0);
    chk("rst_link_vc",    {31'd0, link_vc},    0);
    chk("rst_link_sop",   {31'd0, link_sop},   0);
    chk("rst_link_eop",   {31'd0, link_eop},   0);
    chk("rst_vc_ready",   {30'd0, vc_ready},   32'h3);
    chk("rst_err_ovf",    {31'd0, err_credit_ovf}, 0);
    chk("rst_err_proto",  {31'd0, err_protocol},   0);

    // Credit exhaustion on VC0, then one credit back
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01);
      chk("drain_ready", {30'd0, vc_ready}, (i < 3) ? 32'h3 : 32'h2);
    end
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00);
    chk("starved_ready", {30'd0, vc_ready}, 32'h2);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00);
    chk("credit_back_ready", {30'd0, vc_ready}, 32'h3);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01);
    chk("fifth_sent_ready", {30'd0, vc_ready}, 32'h2);

    // Both VCs busy with credits returned as spent: strict alternation from VC0
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, i[0], i[0] ? 2'b10 : 2'b01);
    chk("alt_ready", {30'd0, vc_ready}, 32'h3);
    chk("alt_err_ovf", {31'd0, err_credit_ovf}, 0);

    // VC0 empty: VC1 granted while VC0 gets a credit in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01);
    chk("vc0_empty_ready", {30'd0, vc_ready}, 32'h2);
    cyc(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0, 2'b10);
    chk("cross_ready", {30'd0, vc_ready}, 32'h3);
    cyc(1'b0, 2'b01, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01);
    chk("vc0_reused_ready", {30'd0, vc_ready}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
      chk("vc1_three_left", {30'd0, vc_ready}, (i < 2) ? 32'h2 : 32'h0);
    end
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00);

    // Send+return on VC1 at count 2, then overflow on full VC0
    do_reset();
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b1, 1'b1, 2'b10);
    chk("net0_ready", {30'd0, vc_ready}, 32'h3);
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
    chk("net0_one_left", {30'd0, vc_ready}, 32'h3);
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
    chk("net0_empty", {30'd0, vc_ready}, 32'h1);
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00);
    chk("pre_ovf", {31'd0, err_credit_ovf}, 0);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    chk("ovf_set", {31'd0, err_credit_ovf}, 1);
    idle(2);
    chk("ovf_sticky", {31'd0, err_credit_ovf}, 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01);
    chk("ovf_count_held", {30'd0, vc_ready}, 32'h0);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00);

    // Protocol checks on VC0
    do_reset();
    chk("ovf_cleared", {31'd0, err_credit_ovf}, 0);
    cyc(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01);
    chk("proto_nosop", {31'd0, err_protocol}, 1);
    do_reset();
    chk("proto_cleared", {31'd0, err_protocol}, 0);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01);
    chk("proto_single", {31'd0, err_protocol}, 0);
    cyc(1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01);
    cyc(1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01);
    cyc(1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 2'b01);
    chk("proto_three_flit", {31'd0, err_protocol}, 0);
    cyc(1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01);
    chk("proto_head_ok", {31'd0, err_protocol}, 0);
    cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01);
    chk("proto_sop_in_pkt", {31'd0, err_protocol}, 1);

    // Reset mid-packet with both counters at 1 and pointer at VC1
    do_reset();
    cyc(1'b0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 2'b11, 2'b11, 2'b10, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 2'b01);
    chk("mid_pkt_ready", {30'd0, vc_ready}, 32'h3);
    cyc(1'b1, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 2'b00);
    chk("midrst_link_valid", {31'd0, link_valid}, 0);
    chk("midrst_ready", {30'd0, vc_ready}, 32'h3);
    chk("midrst_err_proto", {31'd0, err_protocol}, 0);
    cyc(1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01);
    chk("midrst_fsm_idle", {31'd0, err_protocol}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01);
      chk("midrst_counter_full", {30'd0, vc_ready}, (i < 2) ? 32'h3 : 32'h2);
    end

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end
endmodule
